rgb_sort: RTL and testbench

RGB_SORT -- requirements
Module: RGBSort

---
 rtl/rgb_sort.sv | 158 +++++++++++++++
 tb/tb_rgb_sort.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sort.sv
// Nearest-palette tile classifier: latches 16 RGB tiles and labels one per
// cycle against a fixed 16-entry palette using Manhattan distance.
module rgb_sort (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [23:0] i_block0,
  input  logic [23:0] i_block1,
  input  logic [23:0] i_block2,
  input  logic [23:0] i_block3,
  input  logic [23:0] i_block4,
  input  logic [23:0] i_block5,
  input  logic [23:0] i_block6,
  input  logic [23:0] i_block7,
  input  logic [23:0] i_block8,
  input  logic [23:0] i_block9,
  input  logic [23:0] i_block10,
  input  logic [23:0] i_block11,
  input  logic [23:0] i_block12,
  input  logic [23:0] i_block13,
  input  logic [23:0] i_block14,
  input  logic [23:0] i_block15,
  output logic [63:0] o_order,
  output logic        o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] order_q, order_d;
  logic        done_q, done_d;
  logic        cap;
  logic [23:0] in_blk [16];
  logic [23:0] blk_q  [16];

  assign in_blk[0]  = i_block0;
  assign in_blk[1]  = i_block1;
  assign in_blk[2]  = i_block2;
  assign in_blk[3]  = i_block3;
  assign in_blk[4]  = i_block4;
  assign in_blk[5]  = i_block5;
  assign in_blk[6]  = i_block6;
  assign in_blk[7]  = i_block7;
  assign in_blk[8]  = i_block8;
  assign in_blk[9]  = i_block9;
  assign in_blk[10] = i_block10;
  assign in_blk[11] = i_block11;
  assign in_blk[12] = i_block12;
  assign in_blk[13] = i_block13;
  assign in_blk[14] = i_block14;
  assign in_blk[15] = i_block15;

  function automatic logic [23:0] pal(input logic [3:0] l);
    case (l)
      4'd0:  pal = 24'hFF7FFF;
      4'd1:  pal = 24'hFFFFFF;
      4'd2:  pal = 24'hFFFF00;
      4'd3:  pal = 24'hFF7F00;
      4'd4:  pal = 24'hFF007F;
      4'd5:  pal = 24'hFF0000;
      4'd6:  pal = 24'h7FFF7F;
      4'd7:  pal = 24'h7F7F00;
      4'd8:  pal = 24'h7F00FF;
      4'd9:  pal = 24'h7F0000;
      4'd10: pal = 24'h00FFFF;
      4'd11: pal = 24'h00FF00;
      4'd12: pal = 24'h007FFF;
      4'd13: pal = 24'h007F00;
      4'd14: pal = 24'h0000FF;
      4'd15: pal = 24'h000000;
    endcase
  endfunction

  function automatic logic [9:0] absd(input logic [7:0] a,
                                      input logic [7:0] b);
    absd = (a > b) ? {2'b00, a - b} : {2'b00, b - a};
  endfunction

  logic [23:0] cur_c, tab_c;
  logic [9:0]  dist_c, best_c;
  logic [3:0]  label_c;

  // Strict less-than keeps the lowest label on equal distances.
  always_comb begin
    cur_c   = blk_q[k_q];
    tab_c   = '0;
    dist_c  = '0;
    best_c  = 10'h3FF;
    label_c = '0;
    for (int i = 0; i < 16; i++) begin
      tab_c  = pal(4'(i));
      dist_c = absd(cur_c[23:16], tab_c[23:16])
             + absd(cur_c[15:8],  tab_c[15:8])
             + absd(cur_c[7:0],   tab_c[7:0]);
      if (dist_c < best_c) begin
        best_c  = dist_c;
        label_c = 4'(i);
      end
    end
  end

  assign cap = (state_q == S_IDLE) && i_start;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    order_d  = order_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        shadow_d[{~k_q, 2'b00} +: 4] = label_c;
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        order_d = shadow_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      shadow_q <= '0;
      order_q  <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      order_q  <= order_d;
      done_q   <= done_d;
      if (cap) begin
        for (int i = 0; i < 16; i++) blk_q[i] <= in_blk[i];
      end
    end
  end

  assign o_order = order_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_rgb_sort.sv
// Randomized scoreboard bench for rgb_sort against a nearest-colour model.
module tb_rgb_sort;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] blk [16];
  logic [63:0] o_order;
  logic        o_done;

  always #5 clk = ~clk;

  rgb_sort dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_block0(blk[0]),   .i_block1(blk[1]),
    .i_block2(blk[2]),   .i_block3(blk[3]),
    .i_block4(blk[4]),   .i_block5(blk[5]),
    .i_block6(blk[6]),   .i_block7(blk[7]),
    .i_block8(blk[8]),   .i_block9(blk[9]),
    .i_block10(blk[10]), .i_block11(blk[11]),
    .i_block12(blk[12]), .i_block13(blk[13]),
    .i_block14(blk[14]), .i_block15(blk[15]),
    .o_order(o_order), .o_done(o_done)
  );

  logic [23:0] tbl [16] = '{
    24'hFF7FFF, 24'hFFFFFF, 24'hFFFF00, 24'hFF7F00,
    24'hFF007F, 24'hFF0000, 24'h7FFF7F, 24'h7F7F00,
    24'h7F00FF, 24'h7F0000, 24'h00FFFF, 24'h00FF00,
    24'h007FFF, 24'h007F00, 24'h0000FF, 24'h000000
  };

  typedef struct {
    logic [63:0] order;
    int          cap;
  } exp_t;

  exp_t sb [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [63:0] prev_order = '0;

  always @(posedge clk) cyc++;

  function automatic int cdist(logic [23:0] a, logic [23:0] b);
    int s = 0;
    for (int c = 0; c < 3; c++) begin
      int x = int'(a[8*c +: 8]);
      int y = int'(b[8*c +: 8]);
      s += (x > y) ? x - y : y - x;
    end
    return s;
  endfunction

  function automatic logic [3:0] nearest(logic [23:0] c);
    int best = 1 << 20;
    logic [3:0] lab = '0;
    for (int i = 0; i < 16; i++) begin
      if (cdist(c, tbl[i]) < best) begin
        best = cdist(c, tbl[i]);
        lab  = 4'(i);
      end
    end
    return lab;
  endfunction

  function automatic logic [63:0] model();
    logic [63:0] r = '0;
    for (int b = 0; b < 16; b++) r[4*(15-b) +: 4] = nearest(blk[b]);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      total++;
      if (o_order !== 64'h0 || o_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_state order=%h done=%b want 0/0",
                 o_order, o_done);
      end
    end else if (o_done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done at cyc=%0d order=%h", cyc, o_order);
      end else begin
        e = sb.pop_front();
        total++;
        if (o_order !== e.order) begin
          bad++;
          $display("FAIL order got=%h want=%h", o_order, e.order);
        end
        total++;
        if (cyc - e.cap != 17) begin
          bad++;
          $display("FAIL latency got=%0d want=17", cyc - e.cap);
        end
      end
    end else if (o_order !== prev_order) begin
      total++;
      bad++;
      $display("FAIL order_changed got=%h was=%h without done",
               o_order, prev_order);
    end
    prev_order = o_order;
  end

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic scramble();
    for (int b = 0; b < 16; b++) blk[b] = 24'($urandom);
  endtask

  task automatic run_one(input logic [63:0] want, input bit use_model);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e.order = use_model ? model() : want;
    @(posedge clk);
    #1;
    e.cap = cyc;
    sb.push_back(e);
    start = 1'b0;
    scramble();
    drain(40);
  endtask

  task automatic rand_blocks();
    for (int b = 0; b < 16; b++) begin
      logic [23:0] t;
      t = tbl[$urandom_range(0, 15)];
      case ($urandom_range(0, 2))
        0: blk[b] = 24'($urandom);
        1: blk[b] = t;
        default: blk[b] = t ^ 24'($urandom_range(0, 24'h0F0F0F));
      endcase
    end
  endtask

  int seq [16] = '{12, 10, 14, 0, 8, 4, 6, 2, 13, 11, 15, 1, 7, 3, 5, 9};

  initial begin
    exp_t e;
    int c0;
    rst = 1'b1;
    start = 1'b0;
    for (int b = 0; b < 16; b++) blk[b] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int b = 0; b < 16; b++) blk[b] = tbl[seq[b]];
    run_one(64'hCAE0_8462_DBF1_7359, 1'b0);

    for (int b = 0; b < 16; b++) blk[b] = 24'hFFFFFF;
    run_one(64'h1111_1111_1111_1111, 1'b0);

    for (int b = 0; b < 16; b++) blk[b] = 24'h000000;
    blk[0]  = 24'hF0F0F0;
    blk[15] = 24'h10100A;
    run_one(64'h1FFF_FFFF_FFFF_FFFF, 1'b0);

    // 00BFFF sits 64 from both label 10 and label 12.
    for (int b = 0; b < 16; b++) blk[b] = 24'h00BFFF;
    run_one(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);

    for (int b = 0; b < 16; b++) blk[b] = 24'h3F3FBF;
    run_one('0, 1'b1);

    for (int r = 0; r < 20; r++) begin
      rand_blocks();
      run_one('0, 1'b1);
    end

    // Reset in the middle of a run: no done, order cleared.
    rand_blocks();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (o_order !== 64'h0) begin
      bad++;
      $display("FAIL post_abort_order got=%h want=0", o_order);
    end
    rand_blocks();
    run_one('0, 1'b1);

    // Continuous start: back-to-back runs every 18 cycles.
    rand_blocks();
    @(negedge clk);
    start = 1'b1;
    e.order = model();
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int j = 0; j < 4; j++) begin
      e.cap = c0 + 18 * j;
      sb.push_back(e);
    end
    repeat (55) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain(100);
    repeat (25) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
